// File: rtl/pf_mem_responder.sv
// Prefetch line responder: queues line requests, fetches each line as a burst of
// memory beats, and returns the assembled line with a one-cycle done pulse.
module pf_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int CL_SIZE    = 128,  // instruction cache line width
  parameter int BEAT_WIDTH = 32,
  parameter int REQ_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  req_full_o,
  output logic [CL_SIZE-1:0]    data_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i
);

  localparam int NBEATS     = CL_SIZE / BEAT_WIDTH;
  localparam int CNT_W      = $clog2(NBEATS) + 1;
  localparam int PTR_W      = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int FCNT_W     = $clog2(REQ_DEPTH + 1);
  localparam int OFF_BITS   = $clog2(CL_SIZE / 8);
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [CNT_W-1:0]      NBEATS_CNT = CNT_W'(NBEATS);
  localparam logic [FCNT_W-1:0]     DEPTH_CNT  = FCNT_W'(REQ_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FCNT_W-1:0]     count;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      issued;
  logic [CNT_W-1:0]      recv;
  logic [CL_SIZE-1:0]    line;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  issuing;
  logic                  grant;
  logic                  beat_in;
  logic [CNT_W-1:0]      issued_nxt;
  logic [CNT_W-1:0]      recv_nxt;
  logic [ADDR_WIDTH-1:0] offset;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == DEPTH_CNT);
  assign push    = req_i && !full && !flush_i;
  assign pop     = (state == IDLE) && (count != '0) && !flush_i;
  // A flush withdraws the request in the same cycle, so a grant then is not counted.
  assign issuing = (state == ISSUE) && !flush_i;
  assign grant   = issuing && mem_gnt_i;
  // Stray returns with nothing outstanding are ignored.
  assign beat_in = mem_rvalid_i && (issued != recv);

  assign issued_nxt = issued + CNT_W'(grant);
  assign recv_nxt   = recv + CNT_W'(beat_in);
  assign offset     = ADDR_WIDTH'(issued) * ADDR_WIDTH'(BEAT_BYTES);

  assign req_full_o = full;
  assign mem_req_o  = issuing;
  assign mem_addr_o = issuing ? base + offset : '0;
  assign done_o     = (state == RESP) && !flush_i;
  assign data_o     = done_o ? line : '0;

  // NOTE: request storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= addr_i & LINE_MASK;
  end

  // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      base   <= '0;
      issued <= '0;
      recv   <= '0;
      line   <= '0;
    end else begin
      issued <= issued_nxt;
      recv   <= recv_nxt;
      if (beat_in) begin
        for (int b = 0; b < NBEATS; b++) begin
          if (recv == CNT_W'(b)) line[b*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
        end
      end

      case (state)
        IDLE: begin
          if (pop) begin
            base   <= fifo_mem[rd_ptr];
            issued <= '0;
            recv   <= '0;
            line   <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_i) begin
            state <= (issued_nxt > recv_nxt) ? DRAIN : IDLE;
          end else if (grant && issued_nxt == NBEATS_CNT) begin
            state <= (recv_nxt == NBEATS_CNT) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state <= (issued_nxt > recv_nxt) ? DRAIN : IDLE;
          end else if (recv_nxt == NBEATS_CNT) begin
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        // Outstanding beats of an abandoned line must be absorbed before the next one starts.
        DRAIN: begin
          if (recv_nxt == issued_nxt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
